// File: rtl/fd_pipeline_reg_pkg.sv
// Shared constants for the F->D pipeline register. The macros mirror the
// core_param.v defines and are only set here when the core has not set them.
`ifndef PLFLUSH_ENABLE
`define PLFLUSH_ENABLE 1'b1
`endif
`ifndef PLFLUSH_DISABLE
`define PLFLUSH_DISABLE 1'b0
`endif
`ifndef NOP_INST
`define NOP_INST 32'h00000013
`endif
`ifndef FD_BUF_DEPTH
`define FD_BUF_DEPTH 2
`endif

package fd_pipeline_reg_pkg;
  localparam int unsigned FD_XLEN      = 32;
  localparam logic [31:0] FD_NOP_INST  = `NOP_INST;
  localparam int unsigned FD_BUF_DEPTH = `FD_BUF_DEPTH;
  localparam logic        FD_FLUSH_ON  = `PLFLUSH_ENABLE;
  localparam logic        FD_FLUSH_OFF = `PLFLUSH_DISABLE;

  function automatic int unsigned fd_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/fd_fetch_buf.sv
// Small synchronous FIFO of {pc, inst} fetch responses. Clear wins over
// push/pop; pointers wrap modulo DEPTH and the count is held separately.
module fd_fetch_buf
  import fd_pipeline_reg_pkg::*;
#(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = fd_ptr_w(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  logic [W-1:0]  din_i,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_o
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_do_push = push_i && !clear_i;
  assign w_do_pop  = pop_i && !clear_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din_i;
  end

  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];
endmodule

// File: rtl/fd_pipeline_reg.sv
// F->D pipeline register with a small fetch-response buffer: absorbs responses
// during decode stalls and drops wrong-path responses after a flush.
module fd_pipeline_reg
  import fd_pipeline_reg_pkg::*;
#(
  parameter int unsigned       XLEN     = FD_XLEN,
  parameter logic [XLEN-1:0]   NOP_INST = `NOP_INST,
  parameter int unsigned       DEPTH    = FD_BUF_DEPTH
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            imem_req_fire_i,
  output logic            fetch_ready_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_inst_i,
  input  logic [XLEN-1:0] imem_rsp_pc_i,
  input  logic            pipeline_Flush_i,
  input  logic            stall_d_i,
  output logic [XLEN-1:0] inst_d_o,
  output logic [XLEN-1:0] pc_d_o,
  output logic            valid_d_o
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]     r_out_cnt;
  logic [CW-1:0]     r_kill_cnt;
  logic [XLEN-1:0]   r_inst_d;
  logic [XLEN-1:0]   r_pc_d;
  logic              r_valid_d;
  logic              w_flush;
  logic              w_kill;
  logic              w_live;
  logic              w_buf_empty;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_buf_cnt;
  logic [CW-1:0]     w_out_cnt_nxt;
  logic [2*XLEN-1:0] w_buf_head;

  assign w_flush       = (pipeline_Flush_i == `PLFLUSH_ENABLE);
  assign w_kill        = imem_rsp_valid_i && ((r_kill_cnt != '0) || w_flush);
  assign w_live        = imem_rsp_valid_i && !w_kill;
  assign w_buf_empty   = (w_buf_cnt == '0);
  assign w_pop         = !w_flush && !stall_d_i && !w_buf_empty;
  // Bypass straight into D only when nothing older is waiting.
  assign w_push        = w_live && (stall_d_i || !w_buf_empty);
  assign w_out_cnt_nxt = r_out_cnt + CW'(imem_req_fire_i) - CW'(imem_rsp_valid_i);
  assign fetch_ready_o = ({1'b0, r_out_cnt} + {1'b0, w_buf_cnt}) < (CW + 1)'(DEPTH);

  fd_fetch_buf #(
    .W     (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .clear_i (w_flush),
    .din_i   ({imem_rsp_pc_i, imem_rsp_inst_i}),
    .count_o (w_buf_cnt),
    .head_o  (w_buf_head)
  );

  // Every response still owed at flush time belongs to the wrong path.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_out_cnt  <= '0;
      r_kill_cnt <= '0;
    end else begin
      r_out_cnt <= w_out_cnt_nxt;
      if (w_flush) r_kill_cnt <= w_out_cnt_nxt;
      else if (imem_rsp_valid_i && r_kill_cnt != '0) r_kill_cnt <= r_kill_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_inst_d  <= NOP_INST;
      r_pc_d    <= '0;
      r_valid_d <= 1'b0;
    end else if (w_flush) begin
      r_inst_d  <= NOP_INST;
      r_valid_d <= 1'b0;
    end else if (!stall_d_i) begin
      if (!w_buf_empty) begin
        {r_pc_d, r_inst_d} <= w_buf_head;
        r_valid_d          <= 1'b1;
      end else if (w_live) begin
        r_pc_d    <= imem_rsp_pc_i;
        r_inst_d  <= imem_rsp_inst_i;
        r_valid_d <= 1'b1;
      end else begin
        r_inst_d  <= NOP_INST;
        r_valid_d <= 1'b0;
      end
    end
  end

  assign inst_d_o  = r_inst_d;
  assign pc_d_o    = r_pc_d;
  assign valid_d_o = r_valid_d;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_n_i) begin
      assert (!(w_push && !w_flush && w_buf_cnt == CW'(DEPTH)))
        else $error("fd_pipeline_reg: push into full fetch buffer");
      assert (!(imem_rsp_valid_i && r_out_cnt == '0))
        else $error("fd_pipeline_reg: response with no outstanding request");
      assert (!(imem_req_fire_i && !fetch_ready_o))
        else $error("fd_pipeline_reg: request accepted while not ready");
    end
  end
`endif
endmodule
